// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program-counter unit.
//   - default parameter values for pc_unit
//   - run-control state enum (IDLE / RUN / HALT)
//   - next-PC source select enum (TRAP / REDIR / HOLD / RAS / SEQ)
package pc_pkg;

  localparam int unsigned PC_W_DEF      = 32;
  localparam int unsigned INC_DEF       = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0080;
  localparam int unsigned RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } run_state_e;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_HOLD,
    SEL_RAS,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk_i    clock
//   rst_i    asynchronous active-low reset (empties the stack)
//   clear_i  synchronous clear, beats push/pop
//   push_i   push data_i
//   pop_i    pop the top entry (ignored when empty)
//   data_i   W-bit link address to push
//   top_o    current top entry (undefined when empty)
//   empty_o  no entries held
//   full_o   DEPTH entries held
// push_i and pop_i together on a non-empty stack replace the top entry.
// Pushing when full overwrites the oldest entry; the count saturates.
module pc_ras #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     mem [DEPTH];

  logic             do_replace;
  logic             do_push;
  logic             do_pop;
  logic [PTR_W-1:0] wr_idx;

  // DEPTH is a power of two, so the pointer wraps for free and a push onto
  // a full stack lands on the oldest slot.
  always_comb begin
    empty_o    = (count_q == '0);
    full_o     = (count_q == CNT_W'(DEPTH));
    do_replace = push_i && pop_i && !empty_o;
    do_push    = push_i && !do_replace;
    do_pop     = pop_i && !push_i && !empty_o;
    wr_idx     = do_replace ? ptr_q : ptr_q + PTR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (do_push) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (!full_o) count_q <= count_q + CNT_W'(1);
    end else if (do_pop) begin
      ptr_q   <= ptr_q - PTR_W'(1);
      count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; count_q alone says which entries
  // are meaningful, so resetting the data would only cost flops.
  always_ff @(posedge clk_i) begin
    if (!clear_i && (do_push || do_replace)) mem[wr_idx] <= data_i;
  end

  assign top_o = mem[ptr_q];

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with run control and optional RAS.
//   clk_i             clock
//   rst_i             asynchronous active-low reset
//   start_i           run enable; low forces IDLE, RESET_VEC and clears RAS
//   stall_i, hold_i   hold PC and RAS while running
//   halt_i            stop fetching (enter HALT)
//   redirect_valid_i  take redirect_pc_i next cycle
//   redirect_pc_i     branch/jump target
//   trap_valid_i      take TRAP_VEC next cycle (beats redirect)
//   call_i, ret_i     instruction at pc_o is a call / return
//   pc_o              current fetch address
//   pc_valid_o        FSM in RUN
//   halted_o          FSM in HALT
//   ras_empty_o       RAS holds no entries (tied 1 without the RAS)
// Build option: define PC_UNIT_RAS_EN to include the return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned INC       = INC_DEF,
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            hold_i,
  input  logic            halt_i,
  input  logic            redirect_valid_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [PC_W-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            halted_o,
  output logic            ras_empty_o
);

  localparam logic [PC_W-1:0] INC_PC   = PC_W'(INC);
  localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] TRAP_PC  = PC_W'(TRAP_VEC);

  run_state_e      state_q, state_d;
  pc_sel_e         sel;
  logic [PC_W-1:0] pc_q, pc_d, pc_seq;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ras_act;    // RUN, not redirected/stalled/halting
  logic            ras_clear;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    sel       = SEL_HOLD;
    ras_act   = 1'b0;
    ras_clear = 1'b0;
    pc_seq    = pc_q + INC_PC;

    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;  // pc_q is already RESET_PC in IDLE
      ST_RUN: begin
        if (trap_valid_i)                 sel = SEL_TRAP;
        else if (redirect_valid_i)        sel = SEL_REDIR;
        else if (stall_i || hold_i)       sel = SEL_HOLD;
        else if (halt_i)                  state_d = ST_HALT;
        else begin
          ras_act = 1'b1;
          // A return with an empty stack (or no stack) falls through to SEQ.
          sel = (ret_i && !ras_empty) ? SEL_RAS : SEL_SEQ;
        end
      end
      ST_HALT: begin
        if (trap_valid_i) begin
          state_d = ST_RUN;
          sel     = SEL_TRAP;
        end else if (redirect_valid_i) begin
          state_d = ST_RUN;
          sel     = SEL_REDIR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (sel)
      SEL_TRAP:  pc_d = TRAP_PC;
      SEL_REDIR: pc_d = redirect_pc_i;
      SEL_RAS:   pc_d = ras_top;
      SEL_SEQ:   pc_d = pc_seq;
      default:   pc_d = pc_q;
    endcase

    // Dropping start_i overrides everything, in every state.
    if (!start_i) begin
      state_d   = ST_IDLE;
      pc_d      = RESET_PC;
      ras_act   = 1'b0;
      ras_clear = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_UNIT_RAS_EN
  logic ras_full_unused;

  // call+ret on an empty stack degrades to a plain push because pop is
  // masked by ras_empty; the PC then takes the sequential path above.
  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (ras_clear),
    .push_i  (ras_act && call_i),
    .pop_i   (ras_act && ret_i && !ras_empty),
    .data_i  (pc_seq),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full_unused)
  );
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_ras_sigs;

  assign ras_top         = '0;
  assign ras_empty       = 1'b1;
  assign unused_ras_sigs = ^{call_i, ret_i, ras_act, ras_clear};
`endif

  assign pc_o        = pc_q;
  assign pc_valid_o  = (state_q == ST_RUN);
  assign halted_o    = (state_q == ST_HALT);
  assign ras_empty_o = ras_empty;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized bench for pc_unit with a behavioural
// reference model (run/halt flags, PC value, RAS as a bounded queue).
module tb_pc_unit;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [PC_W-1:0] RST_PC  = 32'h0;
  localparam logic [PC_W-1:0] TRAP_PC = 32'h80;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            start_i = 1'b0;
  logic            stall_i = 1'b0;
  logic            hold_i = 1'b0;
  logic            halt_i = 1'b0;
  logic            redirect_valid_i = 1'b0;
  logic [PC_W-1:0] redirect_pc_i = '0;
  logic            trap_valid_i = 1'b0;
  logic            call_i = 1'b0;
  logic            ret_i = 1'b0;
  logic [PC_W-1:0] pc_o;
  logic            pc_valid_o;
  logic            halted_o;
  logic            ras_empty_o;

  pc_unit #(
    .PC_W      (PC_W),
    .INC       (4),
    .RESET_VEC (32'h0),
    .TRAP_VEC  (32'h80),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .stall_i          (stall_i),
    .hold_i           (hold_i),
    .halt_i           (halt_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_valid_i     (trap_valid_i),
    .call_i           (call_i),
    .ret_i            (ret_i),
    .pc_o             (pc_o),
    .pc_valid_o       (pc_valid_o),
    .halted_o         (halted_o),
    .ras_empty_o      (ras_empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  bit              m_run, m_halt;
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_ras[$];

  function automatic void m_push(input logic [PC_W-1:0] v);
    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
    m_ras.push_back(v);
  endfunction

  function automatic void model_step();
    logic [PC_W-1:0] link;
    link = m_pc + PC_W'(4);
    if (!start_i) begin
      m_run = 0; m_halt = 0; m_pc = RST_PC; m_ras.delete();
    end else if (!m_run && !m_halt) begin
      m_run = 1;
    end else if (trap_valid_i || redirect_valid_i) begin
      m_pc = trap_valid_i ? TRAP_PC : redirect_pc_i;
      m_run = 1; m_halt = 0;
    end else if (m_halt) begin
      // stays halted
    end else if (stall_i || hold_i) begin
      // hold
    end else if (halt_i) begin
      m_run = 0; m_halt = 1;
    end else if (RAS_EN && call_i && ret_i) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras[m_ras.size()-1];
        m_ras[m_ras.size()-1] = link;
      end else begin
        m_push(link);
        m_pc = link;
      end
    end else if (RAS_EN && call_i) begin
      m_push(link);
      m_pc = link;
    end else if (RAS_EN && ret_i && m_ras.size() > 0) begin
      m_pc = m_ras.pop_back();
    end else begin
      m_pc = link;
    end
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_run = 0; m_halt = 0; m_pc = RST_PC; m_ras.delete();
    end else begin
      model_step();
    end
  end

  // Cycle-by-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    logic exp_empty;
    exp_empty = RAS_EN ? (m_ras.size() == 0) : 1'b1;
    n_tests++;
    if (pc_o !== m_pc || pc_valid_o !== m_run || halted_o !== m_halt ||
        ras_empty_o !== exp_empty) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t: got pc=%h valid=%b halted=%b empty=%b, expected pc=%h valid=%b halted=%b empty=%b",
               $time, pc_o, pc_valid_o, halted_o, ras_empty_o, m_pc, m_run, m_halt, exp_empty);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_ctl();
    stall_i = 0; hold_i = 0; halt_i = 0; redirect_valid_i = 0;
    trap_valid_i = 0; call_i = 0; ret_i = 0;
  endtask

  task automatic rand_inputs();
    start_i          = ($urandom_range(99) < 97);
    trap_valid_i     = ($urandom_range(99) < 3);
    redirect_valid_i = ($urandom_range(99) < 8);
    stall_i          = ($urandom_range(99) < 15);
    hold_i           = ($urandom_range(99) < 5);
    halt_i           = ($urandom_range(99) < 4);
    call_i           = ($urandom_range(99) < 20);
    ret_i            = ($urandom_range(99) < 20);
    if ($urandom_range(9) == 0) redirect_pc_i = 32'hFFFF_FFF0 | PC_W'($urandom_range(15));
    else                        redirect_pc_i = PC_W'($urandom) & ~PC_W'(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    check("reset_pc", pc_o, RST_PC);
    check("reset_valid", pc_valid_o, 0);
    check("reset_halted", halted_o, 0);
    check("reset_empty", ras_empty_o, 1);
    rst_i = 1;
    tick();
    check("idle_pc", pc_o, 0);
    check("idle_valid", pc_valid_o, 0);

    start_i = 1;
    tick();
    check("run_first_pc", pc_o, 0);
    check("run_first_valid", pc_valid_o, 1);
    tick(); check("seq_4", pc_o, 4);
    tick(); check("seq_8", pc_o, 8);
    tick(); check("seq_12", pc_o, 12);
    tick(); check("seq_16", pc_o, 32'h10);

    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", pc_o, 32'h10);
    end
    redirect_valid_i = 1; redirect_pc_i = 32'h200;
    tick(); check("redirect_beats_stall", pc_o, 32'h200);
    clear_ctl();

    redirect_valid_i = 1; redirect_pc_i = 32'h20;
    tick(); clear_ctl();
    halt_i = 1;
    tick();
    check("halt_halted", halted_o, 1);
    check("halt_pc", pc_o, 32'h20);
    check("halt_valid", pc_valid_o, 0);
    halt_i = 0; call_i = 1; ret_i = 1; stall_i = 1;
    tick();
    check("halt_stays_pc", pc_o, 32'h20);
    check("halt_stays", halted_o, 1);
    clear_ctl();
    trap_valid_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h300;
    tick();
    check("trap_pc", pc_o, 32'h80);
    check("trap_run", pc_valid_o, 1);
    check("trap_not_halted", halted_o, 0);
    clear_ctl();
    tick(); check("after_trap_seq", pc_o, 32'h84);

    redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
    tick(); clear_ctl();
    check("pre_wrap", pc_o, 32'hFFFF_FFFC);
    tick(); check("wrap", pc_o, 0);

    ret_i = 1;
    tick();
    check("ret_empty_seq", pc_o, 4);
    check("ret_empty_flag", ras_empty_o, 1);
    clear_ctl();

`ifdef PC_UNIT_RAS_EN
    redirect_valid_i = 1; redirect_pc_i = 32'h40; tick(); clear_ctl();
    call_i = 1; tick(); check("call1_seq", pc_o, 32'h44); clear_ctl();
    redirect_valid_i = 1; redirect_pc_i = 32'h100; tick(); clear_ctl();
    call_i = 1; tick(); check("call2_seq", pc_o, 32'h104); clear_ctl();
    check("ras_not_empty", ras_empty_o, 0);
    ret_i = 1;
    tick(); check("ret1", pc_o, 32'h104);
    tick(); check("ret2", pc_o, 32'h44);
    tick(); check("ret3_seq", pc_o, 32'h48);
    check("ras_empty_again", ras_empty_o, 1);
    clear_ctl();

    redirect_valid_i = 1; redirect_pc_i = 32'h500; tick(); clear_ctl();
    call_i = 1;
    for (int i = 0; i < 5; i++) tick();
    check("five_calls_pc", pc_o, 32'h514);
    clear_ctl();
    ret_i = 1;
    tick(); check("ovf_ret1", pc_o, 32'h514);
    tick(); check("ovf_ret2", pc_o, 32'h510);
    tick(); check("ovf_ret3", pc_o, 32'h50C);
    tick(); check("ovf_ret4", pc_o, 32'h508);
    tick(); check("ovf_ret5_seq", pc_o, 32'h50C);
    check("ovf_empty", ras_empty_o, 1);
    clear_ctl();

    redirect_valid_i = 1; redirect_pc_i = 32'h600; tick(); clear_ctl();
    call_i = 1; tick(); check("rep_call", pc_o, 32'h604);
    ret_i = 1; tick(); check("rep_callret", pc_o, 32'h604);
    call_i = 0; tick(); check("rep_ret", pc_o, 32'h608);
    clear_ctl();
`endif

    call_i = 1; tick(); clear_ctl();
`ifdef PC_UNIT_RAS_EN
    check("drop_pre_nonempty", ras_empty_o, 0);
`endif
    start_i = 0;
    tick();
    check("drop_pc", pc_o, 0);
    check("drop_valid", pc_valid_o, 0);
    check("drop_empty", ras_empty_o, 1);
    start_i = 1;
    tick();

    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      if (c == 1500) begin
        @(posedge clk_i);
        #3 rst_i = 0;
        #1;
        check("async_rst_pc", pc_o, 0);
        check("async_rst_valid", pc_valid_o, 0);
        check("async_rst_halted", halted_o, 0);
        check("async_rst_empty", ras_empty_o, 1);
        @(posedge clk_i);
        #3 rst_i = 1;
        #1;
        check("post_rst_idle", pc_valid_o, 0);
      end
      tick();
    end

    clear_ctl();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
